// File: rtl/cmd_ximm_enq_queues.sv
// rtl/cmd_ximm_enq_queues.sv - atomic command/immediate enqueue responder with two dequeue FIFOs
module cmd_ximm_enq_queues #(
    parameter int CMD_W        = 20,
    parameter int IMM_W        = 64,
    parameter int CMDQ_DEPTH   = 4,
    parameter int XIMM1Q_DEPTH = 4,
    localparam int CQ_CW       = $clog2(CMDQ_DEPTH + 1),
    localparam int XQ_CW       = $clog2(XIMM1Q_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_valid,
    input  logic             io_sigs_enq_cmdq,
    input  logic             io_sigs_enq_ximm1q,
    input  logic [CMD_W-1:0] io_cmd_bits,
    input  logic [IMM_W-1:0] io_imm_bits,
    output logic             io_replay,
    output logic             io_cmdq_ready,
    output logic             io_ximm1q_ready,
    output logic             io_cmdq_deq_valid,
    input  logic             io_cmdq_deq_ready,
    output logic [CMD_W-1:0] io_cmdq_deq_bits,
    output logic             io_ximm1q_deq_valid,
    input  logic             io_ximm1q_deq_ready,
    output logic [IMM_W-1:0] io_ximm1q_deq_bits,
    output logic [CQ_CW-1:0] io_cmdq_count,
    output logic [XQ_CW-1:0] io_ximm1q_count
);
    localparam int CQ_PW = $clog2(CMDQ_DEPTH);
    localparam int XQ_PW = $clog2(XIMM1Q_DEPTH);
    localparam logic [CQ_CW-1:0] CQ_FULL = CQ_CW'(CMDQ_DEPTH);
    localparam logic [XQ_CW-1:0] XQ_FULL = XQ_CW'(XIMM1Q_DEPTH);

    logic [CMD_W-1:0] cq_mem [CMDQ_DEPTH];
    logic [IMM_W-1:0] xq_mem [XIMM1Q_DEPTH];
    logic [CQ_PW-1:0] cq_head, cq_tail;
    logic [XQ_PW-1:0] xq_head, xq_tail;
    logic [CQ_CW-1:0] cq_count;
    logic [XQ_CW-1:0] xq_count;

    logic fire, cq_push, cq_pop, xq_push, xq_pop;

    // Readiness looks only at registered occupancy, so a same-cycle pop never frees a slot early.
    assign io_cmdq_ready   = (cq_count != CQ_FULL);
    assign io_ximm1q_ready = (xq_count != XQ_FULL);

    assign io_replay = io_valid & ((io_sigs_enq_cmdq & ~io_cmdq_ready) |
                                   (io_sigs_enq_ximm1q & ~io_ximm1q_ready));
    assign fire      = io_valid & ~io_replay;

    assign cq_push = fire & io_sigs_enq_cmdq;
    assign xq_push = fire & io_sigs_enq_ximm1q;
    assign cq_pop  = io_cmdq_deq_valid & io_cmdq_deq_ready;
    assign xq_pop  = io_ximm1q_deq_valid & io_ximm1q_deq_ready;

    assign io_cmdq_deq_valid   = (cq_count != '0);
    assign io_ximm1q_deq_valid = (xq_count != '0);
    assign io_cmdq_deq_bits    = cq_mem[cq_head];
    assign io_ximm1q_deq_bits  = xq_mem[xq_head];
    assign io_cmdq_count       = cq_count;
    assign io_ximm1q_count     = xq_count;

    // Storage carries no reset; stale contents are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (cq_push) cq_mem[cq_tail] <= io_cmd_bits;
        if (xq_push) xq_mem[xq_tail] <= io_imm_bits;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cq_head  <= '0;
            cq_tail  <= '0;
            cq_count <= '0;
        end else begin
            if (cq_push) cq_tail <= cq_tail + CQ_PW'(1);
            if (cq_pop)  cq_head <= cq_head + CQ_PW'(1);
            case ({cq_push, cq_pop})
                2'b10:   cq_count <= cq_count + CQ_CW'(1);
                2'b01:   cq_count <= cq_count - CQ_CW'(1);
                default: cq_count <= cq_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            xq_head  <= '0;
            xq_tail  <= '0;
            xq_count <= '0;
        end else begin
            if (xq_push) xq_tail <= xq_tail + XQ_PW'(1);
            if (xq_pop)  xq_head <= xq_head + XQ_PW'(1);
            case ({xq_push, xq_pop})
                2'b10:   xq_count <= xq_count + XQ_CW'(1);
                2'b01:   xq_count <= xq_count - XQ_CW'(1);
                default: xq_count <= xq_count;
            endcase
        end
    end
endmodule

// File: doc/cmd_ximm_enq_queues.md
Name: cmd_ximm_enq_queues

Overview:
- Responder side of the block-decoder enqueue interface: takes the decoder's per-queue enqueue requests (enq_cmdq, enq_ximm1q) with the instruction's command word and first immediate.
- Pushes the command word into a command FIFO and the immediate into an immediate FIFO, atomically.
- Drives per-queue ready and the replay indication back to issue.
- Exposes two independent valid/ready dequeue ports to the downstream sequencer.

Parameters:
- CMD_W, 20, command word width.
- IMM_W, 64, immediate width.
- CMDQ_DEPTH, 4, command FIFO entries; power of 2, at least 2.
- XIMM1Q_DEPTH, 4, immediate FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- io_valid  in  1  instruction presented this cycle.
- io_sigs_enq_cmdq  in  1  instruction requires a command-FIFO push.
- io_sigs_enq_ximm1q  in  1  instruction requires an immediate-FIFO push.
- io_cmd_bits  in  CMD_W  command word.
- io_imm_bits  in  IMM_W  immediate.
- io_replay  out  1  instruction not accepted; issue must re-present it.
- io_cmdq_ready  out  1  command FIFO not full.
- io_ximm1q_ready  out  1  immediate FIFO not full.
- io_cmdq_deq_valid  out  1  command FIFO non-empty.
- io_cmdq_deq_ready  in  1  consumer takes command head.
- io_cmdq_deq_bits  out  CMD_W  command head entry.
- io_ximm1q_deq_valid  out  1  immediate FIFO non-empty.
- io_ximm1q_deq_ready  in  1  consumer takes immediate head.
- io_ximm1q_deq_bits  out  IMM_W  immediate head entry.
- io_cmdq_count  out  clog2(CMDQ_DEPTH+1)  occupancy.
- io_ximm1q_count  out  clog2(XIMM1Q_DEPTH+1)  occupancy.

Behaviour:
- Ready outputs:
  - io_cmdq_ready = (cmdq_count != CMDQ_DEPTH).
  - io_ximm1q_ready = (ximm1q_count != XIMM1Q_DEPTH).
  - Both are functions of registered occupancy only; no dependence on deq_ready and no same-cycle pop-to-push pass-through.
- Replay:
  - io_replay = io_valid & ((io_sigs_enq_cmdq & ~io_cmdq_ready) | (io_sigs_enq_ximm1q & ~io_ximm1q_ready)).
  - Combinational, zero latency.
- Accept:
  - fire = io_valid & ~io_replay.
  - On fire, each requested FIFO writes its data at its tail; tail and count advance.
  - Push is all-or-nothing: if either requested FIFO is full, neither is written.
  - io_valid with both enq flags low: fire is a no-op with replay 0.
- Dequeue:
  - deq_valid = (count != 0).
  - deq_bits = mem[head], combinational read.
  - Pop when deq_valid & deq_ready; head advances. deq_ready with an empty FIFO is ignored.
- Simultaneous push and pop on one FIFO: count unchanged, both pointers advance.
  - Full FIFO: push is blocked (ready=0); only the pop occurs; ready rises next cycle.
- Empty FIFO: no bypass. A pushed entry appears on deq_bits with deq_valid=1 the cycle after fire (1-cycle latency).
- Wrap: pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count disambiguates full from empty.
- Ordering: each FIFO is strictly in order. The two FIFOs are otherwise independent; the downstream sequencer pairs entries.
- Reset (synchronous, including mid-operation):
  - Pointers and counts go to 0; deq_valid = 0; both ready = 1; contents discarded.
  - Memory is not cleared.
  - io_replay is 0 while the FIFOs are empty, regardless of io_valid.

Test Plan:
- Reset, then io_valid=1, enq_cmdq=1, enq_ximm1q=1, cmd=0x12345, imm=0xDEAD_BEEF. Required: replay=0; next cycle both deq_valid=1, deq_bits match, counts=1.
- 4 cmd-only pushes (cmd 1..4) with deq_ready=0. Required: cmdq_count=4, cmdq_ready=0. Fifth push with enq_cmdq=1 gives replay=1 and count stays 4. Same cycle, a push with enq_ximm1q only gives replay=0.
- Cmdq full, ximm1q empty; present enq_cmdq=1, enq_ximm1q=1. Required: replay=1; ximm1q_count stays 0 (atomicity). Pop one command. Required: next cycle cmdq_ready=1, re-presented instruction fires, both counts update.
- Cmdq count 2; push and pop the same cycle. Required: count stays 2, head advances. Run 10 push/pop pairs across wrap. Required: dequeue order 1..10 exact.
- Cmdq count 3 with valid held high; assert reset for one cycle. Required: next cycle counts=0, deq_valid=0, both ready=1, replay=0. Subsequent push of cmd 0x7 dequeues 0x7, not stale data.
- io_valid=1 with both enq flags 0, FIFOs full. Required: replay=0, counts unchanged.
